// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port on-chip memory port between N requesters using
// round-robin arbitration, with optional locked bursts and tagged read return.
//
// Ports:
//   i_clock, i_reset       clock; synchronous active-low reset
//   i_rd/i_wr/i_lock [N]   per-requester read, write and burst-lock requests
//   i_address [N*AW]       requester i address at [i*AW +: AW]
//   i_writedata [N*DW]     requester i write data at [i*DW +: DW]
//   o_gnt [N]              one-hot grant, combinational, same cycle as access
//   o_rvalid [N]           one-hot read-return strobe, RD_LAT cycles after read
//   o_readdata [DW]        memory read data broadcast, qualified by o_rvalid
//   o_owner, o_locked      current lock owner (0 when unlocked) and lock flag
//   o_mem_*                shared memory port drive
//   i_mem_readdata [DW]    memory read data
module mem_port_arbiter #(
  parameter int N      = 4,
  parameter int AW     = 11,
  parameter int DW     = 256,
  parameter int RD_LAT = 1
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [N-1:0]                 i_rd,
  input  logic [N-1:0]                 i_wr,
  input  logic [N-1:0]                 i_lock,
  input  logic [N*AW-1:0]              i_address,
  input  logic [N*DW-1:0]              i_writedata,
  output logic [N-1:0]                 o_gnt,
  output logic [N-1:0]                 o_rvalid,
  output logic [DW-1:0]                o_readdata,
  output logic [$clog2(N)-1:0]         o_owner,
  output logic                         o_locked,
  output logic [AW-1:0]                o_mem_address,
  output logic                         o_mem_chipselect,
  output logic                         o_mem_clken,
  output logic                         o_mem_write,
  output logic [DW-1:0]                o_mem_writedata,
  output logic [DW/8-1:0]              o_mem_byteenable,
  input  logic [DW-1:0]                i_mem_readdata
);

  localparam int IW = $clog2(N);

  typedef enum logic [0:0] {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_last_ptr;
  logic [IW-1:0]   r_owner;
  logic [RD_LAT-1:0] r_pipe_vld;
  logic [IW-1:0]   r_pipe_idx [RD_LAT];

  logic [N-1:0]    w_req;
  logic            w_rr_found;
  logic [IW-1:0]   w_rr_idx;
  logic [IW-1:0]   w_cand;
  logic            w_gnt_vld;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_sel_rd;

  assign w_req = i_rd | i_wr;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_cand     = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IW'((int'(r_last_ptr) + k) % N);
      if (!w_rr_found && w_req[w_cand]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_cand;
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  // Grant selection and next-state logic.
  always_comb begin
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = '0;
    w_state_nxt = r_state;
    case (r_state)
      ST_FREE: begin
        if (w_rr_found) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_rr_idx;
          if (i_lock[w_rr_idx]) begin
            w_state_nxt = ST_LOCKED;
          end else begin
            w_state_nxt = ST_FREE;
          end
        end else begin
          w_state_nxt = ST_FREE;
        end
      end
      ST_LOCKED: begin
        // Owner keeps the port even while idle; everyone else stalls.
        w_gnt_idx = r_owner;
        w_gnt_vld = w_req[r_owner];
        if (!i_lock[r_owner]) begin
          w_state_nxt = ST_FREE;
        end else begin
          w_state_nxt = ST_LOCKED;
        end
      end
      default: begin
        w_state_nxt = ST_FREE;
      end
    endcase
  end

  // Shared memory port drive from the granted requester.
  always_comb begin
    o_gnt = '0;
    if (w_gnt_vld) begin
      o_gnt[w_gnt_idx] = 1'b1;
      o_mem_address    = i_address[w_gnt_idx*AW +: AW];
      o_mem_writedata  = i_writedata[w_gnt_idx*DW +: DW];
      o_mem_write      = i_wr[w_gnt_idx];
      w_sel_rd         = i_rd[w_gnt_idx] & ~i_wr[w_gnt_idx];
    end else begin
      o_mem_address    = '0;
      o_mem_writedata  = '0;
      o_mem_write      = 1'b0;
      w_sel_rd         = 1'b0;
    end
  end

  assign o_mem_chipselect = w_gnt_vld;
  assign o_mem_clken      = 1'b1;
  assign o_mem_byteenable = {(DW/8){1'b1}};

  // Arbitration state, round-robin pointer and lock owner.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state    <= ST_FREE;
      r_last_ptr <= IW'(N - 1);
      r_owner    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_FREE && w_gnt_vld) begin
        r_last_ptr <= w_gnt_idx;
      end
      // Owner is captured on lock entry and cleared when the lock ends.
      if (w_state_nxt == ST_LOCKED) begin
        if (r_state == ST_FREE) begin
          r_owner <= w_gnt_idx;
        end
      end else begin
        r_owner <= '0;
      end
    end
  end

  // Read-return tag pipeline, one stage per cycle of memory latency.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_pipe_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        r_pipe_idx[k] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= w_sel_rd;
      r_pipe_idx[0] <= w_gnt_idx;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pipe_vld[k] <= r_pipe_vld[k-1];
        r_pipe_idx[k] <= r_pipe_idx[k-1];
      end
    end
  end

  // Decode the last pipeline stage into the one-hot return strobe.
  always_comb begin
    o_rvalid = '0;
    if (r_pipe_vld[RD_LAT-1]) begin
      o_rvalid[r_pipe_idx[RD_LAT-1]] = 1'b1;
    end else begin
      o_rvalid = '0;
    end
  end

  assign o_readdata = i_mem_readdata;
  assign o_owner    = r_owner;
  assign o_locked   = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int N  = 4;
  localparam int AW = 11;
  localparam int DW = 256;
  localparam int IW = 2;

  typedef struct {
    int            idx;
    logic [255:0]  data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: RD_LAT = 1
  logic [N-1:0] a_rd, a_wr, a_lock, a_gnt, a_rvalid;
  logic [N*AW-1:0] a_addr;
  logic [N*DW-1:0] a_wdata;
  logic [DW-1:0] a_rdata, a_mrdata, a_mwdata;
  logic [IW-1:0] a_owner;
  logic a_locked, a_cs, a_clken, a_we;
  logic [AW-1:0] a_maddr;
  logic [DW/8-1:0] a_be;

  // Instance B: RD_LAT = 3
  logic [N-1:0] b_rd, b_wr, b_lock, b_gnt, b_rvalid;
  logic [N*AW-1:0] b_addr;
  logic [N*DW-1:0] b_wdata;
  logic [DW-1:0] b_rdata, b_mrdata, b_mwdata;
  logic [IW-1:0] b_owner;
  logic b_locked, b_cs, b_clken, b_we;
  logic [AW-1:0] b_maddr;
  logic [DW/8-1:0] b_be;

  mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(1)) dut_a (
    .i_clock(clk), .i_reset(rst_n), .i_rd(a_rd), .i_wr(a_wr), .i_lock(a_lock),
    .i_address(a_addr), .i_writedata(a_wdata), .o_gnt(a_gnt), .o_rvalid(a_rvalid),
    .o_readdata(a_rdata), .o_owner(a_owner), .o_locked(a_locked),
    .o_mem_address(a_maddr), .o_mem_chipselect(a_cs), .o_mem_clken(a_clken),
    .o_mem_write(a_we), .o_mem_writedata(a_mwdata), .o_mem_byteenable(a_be),
    .i_mem_readdata(a_mrdata));

  mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(3)) dut_b (
    .i_clock(clk), .i_reset(rst_n), .i_rd(b_rd), .i_wr(b_wr), .i_lock(b_lock),
    .i_address(b_addr), .i_writedata(b_wdata), .o_gnt(b_gnt), .o_rvalid(b_rvalid),
    .o_readdata(b_rdata), .o_owner(b_owner), .o_locked(b_locked),
    .o_mem_address(b_maddr), .o_mem_chipselect(b_cs), .o_mem_clken(b_clken),
    .o_mem_write(b_we), .o_mem_writedata(b_mwdata), .o_mem_byteenable(b_be),
    .i_mem_readdata(b_mrdata));

  function automatic logic [255:0] pat(input logic [10:0] a);
    return {8{8'hAB, 13'h0000, a}};
  endfunction

  function automatic logic [255:0] wpat(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  // Memory models: read data appears RD_LAT cycles after the address.
  logic [DW-1:0] b_md [3];
  always @(posedge clk) begin
    a_mrdata <= pat(a_maddr);
    b_md[0]  <= pat(b_maddr);
    b_md[1]  <= b_md[0];
    b_md[2]  <= b_md[1];
  end
  assign b_mrdata = b_md[2];

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Monitor A: pops expected read returns whenever rvalid shows up.
  always @(negedge clk) begin
    if (qa.size() > 0 && qa[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL a_rvalid_missing: actual none required idx %0d at cycle %0d", qa[0].idx, qa[0].due);
      void'(qa.pop_front());
    end
    if (a_rvalid != '0) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_rvalid_unexpected: actual %b required 0000", a_rvalid);
      end else begin
        ea = qa.pop_front();
        chk("a_rvalid", 256'(a_rvalid), 256'(1 << ea.idx));
        chk("a_readdata", a_rdata, ea.data);
        chk("a_rvalid_cycle", 256'(cyc), 256'(ea.due));
      end
    end
  end

  // Monitor B: same for the RD_LAT = 3 instance.
  always @(negedge clk) begin
    if (qb.size() > 0 && qb[0].due < cyc) begin
      checks++; errors++;
      $display("FAIL b_rvalid_missing: actual none required idx %0d at cycle %0d", qb[0].idx, qb[0].due);
      void'(qb.pop_front());
    end
    if (b_rvalid != '0) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_rvalid_unexpected: actual %b required 0000", b_rvalid);
      end else begin
        eb = qb.pop_front();
        chk("b_rvalid", 256'(b_rvalid), 256'(1 << eb.idx));
        chk("b_readdata", b_rdata, eb.data);
        chk("b_rvalid_cycle", 256'(cyc), 256'(eb.due));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_rd = '0; a_wr = '0; a_lock = '0; a_addr = '0;
    b_rd = '0; b_wr = '0; b_lock = '0; b_addr = '0;
  endtask

  task automatic set_a(input int i, input logic r, input logic w, input logic l, input logic [10:0] ad);
    a_rd[i] = r; a_wr[i] = w; a_lock[i] = l; a_addr[i*AW +: AW] = ad;
  endtask

  task automatic set_b(input int i, input logic r, input logic w, input logic l, input logic [10:0] ad);
    b_rd[i] = r; b_wr[i] = w; b_lock[i] = l; b_addr[i*AW +: AW] = ad;
  endtask

  task automatic exp_a(input int i, input logic [10:0] ad);
    qa.push_back('{idx: i, data: pat(ad), due: cyc + 1});
  endtask

  task automatic exp_b(input int i, input logic [10:0] ad);
    qb.push_back('{idx: i, data: pat(ad), due: cyc + 3});
  endtask

  initial begin
    idle_all();
    for (int i = 0; i < N; i++) begin
      a_wdata[i*DW +: DW] = wpat(i);
      b_wdata[i*DW +: DW] = wpat(i);
    end
    rst_n = 1'b0;
    step(); step();
    #5;
    chk("rst_rvalid", 256'(a_rvalid), 256'd0);
    chk("rst_locked", 256'(a_locked), 256'd0);
    chk("rst_owner", 256'(a_owner), 256'd0);
    chk("rst_gnt", 256'(a_gnt), 256'd0);
    chk("rst_cs", 256'(a_cs), 256'd0);
    chk("rst_clken", 256'(a_clken), 256'd1);
    chk("rst_be", 256'(a_be), 256'hFFFF_FFFF);
    chk("rst_b_locked", 256'(b_locked), 256'd0);

    // Single read from requester 0 right after reset.
    step(); rst_n = 1'b1;
    set_a(0, 1'b1, 1'b0, 1'b0, 11'h005); exp_a(0, 11'h005);
    #5;
    chk("t1_gnt", 256'(a_gnt), 256'h1);
    chk("t1_cs", 256'(a_cs), 256'd1);
    chk("t1_we", 256'(a_we), 256'd0);
    chk("t1_addr", 256'(a_maddr), 256'h005);
    step(); idle_all();

    // Fresh reset, then all four read for 8 cycles.
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      if (k == 0) begin
        for (int i = 0; i < N; i++) set_a(i, 1'b1, 1'b0, 1'b0, 11'(11'h100 + i));
      end
      #5;
      chk("rr_gnt", 256'(a_gnt), 256'(1 << (k % 4)));
      chk("rr_addr", 256'(a_maddr), 256'(11'h100 + (k % 4)));
      exp_a(k % 4, 11'(11'h100 + (k % 4)));
    end
    step(); idle_all();

    // Lock burst by requester 2 while 1 and 3 keep requesting.
    step(); set_a(1, 1'b1, 1'b0, 1'b0, 11'h030);
    #5; chk("p_gnt", 256'(a_gnt), 256'h2); exp_a(1, 11'h030);
    step(); set_a(2, 1'b0, 1'b1, 1'b1, 11'h010); set_a(3, 1'b1, 1'b0, 1'b0, 11'h040);
    #5;
    chk("l0_gnt", 256'(a_gnt), 256'h4);
    chk("l0_we", 256'(a_we), 256'd1);
    chk("l0_addr", 256'(a_maddr), 256'h010);
    chk("l0_wdata", a_mwdata, wpat(2));
    chk("l0_locked", 256'(a_locked), 256'd0);
    step(); set_a(2, 1'b0, 1'b1, 1'b1, 11'h011);
    #5;
    chk("l1_gnt", 256'(a_gnt), 256'h4);
    chk("l1_addr", 256'(a_maddr), 256'h011);
    chk("l1_locked", 256'(a_locked), 256'd1);
    chk("l1_owner", 256'(a_owner), 256'd2);
    step(); set_a(2, 1'b0, 1'b1, 1'b0, 11'h012);
    #5;
    chk("l2_gnt", 256'(a_gnt), 256'h4);
    chk("l2_addr", 256'(a_maddr), 256'h012);
    chk("l2_owner", 256'(a_owner), 256'd2);
    step(); set_a(2, 1'b0, 1'b0, 1'b0, 11'h000);
    #5;
    chk("l3_gnt", 256'(a_gnt), 256'h8);
    chk("l3_locked", 256'(a_locked), 256'd0);
    chk("l3_owner", 256'(a_owner), 256'd0);
    chk("l3_addr", 256'(a_maddr), 256'h040);
    exp_a(3, 11'h040);
    step(); set_a(3, 1'b0, 1'b0, 1'b0, 11'h000);
    #5; chk("l4_gnt", 256'(a_gnt), 256'h2); exp_a(1, 11'h030);
    step(); idle_all();

    // Read and write together: write wins, no read return.
    step(); set_a(1, 1'b1, 1'b1, 1'b0, 11'h020);
    #5;
    chk("rw_gnt", 256'(a_gnt), 256'h2);
    chk("rw_we", 256'(a_we), 256'd1);
    chk("rw_addr", 256'(a_maddr), 256'h020);
    step(); idle_all();
    step();

    // Lock owner 0 idles while requester 3 waits.
    step(); set_a(0, 1'b1, 1'b0, 1'b1, 11'h050);
    #5; chk("i0_gnt", 256'(a_gnt), 256'h1); exp_a(0, 11'h050);
    step(); set_a(0, 1'b0, 1'b0, 1'b1, 11'h050); set_a(3, 1'b1, 1'b0, 1'b0, 11'h060);
    #5;
    chk("i1_gnt", 256'(a_gnt), 256'h0);
    chk("i1_cs", 256'(a_cs), 256'd0);
    chk("i1_addr", 256'(a_maddr), 256'h000);
    chk("i1_locked", 256'(a_locked), 256'd1);
    chk("i1_owner", 256'(a_owner), 256'd0);
    step();
    #5;
    chk("i2_gnt", 256'(a_gnt), 256'h0);
    chk("i2_cs", 256'(a_cs), 256'd0);
    step(); set_a(0, 1'b0, 1'b0, 1'b0, 11'h000);
    #5;
    chk("i3_gnt", 256'(a_gnt), 256'h0);
    chk("i3_locked", 256'(a_locked), 256'd1);
    step();
    #5; chk("i4_gnt", 256'(a_gnt), 256'h8); exp_a(3, 11'h060);
    step(); idle_all();

    // Single requester streaming: granted every cycle, back-to-back returns.
    for (int k = 0; k < 3; k++) begin
      step(); set_a(2, 1'b1, 1'b0, 1'b0, 11'(11'h070 + k));
      #5;
      chk("s_gnt", 256'(a_gnt), 256'h4);
      exp_a(2, 11'(11'h070 + k));
    end
    step(); idle_all();
    step();

    // RD_LAT = 3 instance: reads in flight discarded by reset.
    step(); set_b(0, 1'b1, 1'b0, 1'b0, 11'h001); set_b(1, 1'b1, 1'b0, 1'b0, 11'h002);
    #5; chk("b_a_gnt", 256'(b_gnt), 256'h1);
    step(); set_b(0, 1'b0, 1'b0, 1'b0, 11'h000); set_b(1, 1'b1, 1'b0, 1'b1, 11'h002);
    #5; chk("b_b_gnt", 256'(b_gnt), 256'h2);
    step(); idle_all(); rst_n = 1'b0;
    #5; chk("b_c_locked", 256'(b_locked), 256'd1);
    step(); rst_n = 1'b1;
    set_b(0, 1'b1, 1'b0, 1'b0, 11'h003); set_b(1, 1'b1, 1'b0, 1'b0, 11'h004);
    set_b(2, 1'b1, 1'b0, 1'b0, 11'h005);
    #5;
    chk("b_d_gnt", 256'(b_gnt), 256'h1);
    chk("b_d_locked", 256'(b_locked), 256'd0);
    chk("b_d_owner", 256'(b_owner), 256'd0);
    exp_b(0, 11'h003);
    step(); idle_all();
    for (int k = 0; k < 6; k++) step();
    #5;
    chk("qa_empty", 256'(qa.size()), 256'd0);
    chk("qb_empty", 256'(qb.size()), 256'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
